fetch_align_queue: RTL
======================

Name: fetch_align_queue

Overview:
- Halfword-granular prefetch queue directly upstream of the compressed-extension unit.
- Issues word-aligned I-cache requests and absorbs the returned 32-bit words as 16-bit parcels.
- Presents one complete instruction per handshake, 16-bit or 32-bit, with its PC. A 32-bit instruction that straddles a word boundary is delivered already assembled.
- Redirects on branch/jump: flushes the queue and kills any in-flight request.

Parameters:
- DEPTH_HW, 8, queue capacity in 16-bit parcels; power of 2, minimum 4.
- RESET_PC, 32'h0000_0000, fetch and instruction PC after reset; bit 0 must be 0.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- flush_i  input  1  redirect request (branch taken / jump).
- redirect_pc_i  input  32  redirect target; bit 0 ignored.
- fetch_req_o  output  1  I-cache request valid.
- fetch_addr_o  output  32  request address, bits [1:0] always 2'b00.
- fetch_kill_o  output  1  one-cycle pulse that cancels the outstanding request.
- fetch_valid_i  input  1  I-cache response valid.
- fetch_data_i  input  32  response word, little-endian parcels.
- instr_valid_o  output  1  instr_o/pc_o hold a complete instruction.
- instr_ready_i  input  1  consumer accepts the instruction.
- instr_o  output  32  instruction; compressed instructions are zero-extended in [15:0].
- pc_o  output  32  PC of instr_o.
- is_comp_o  output  1  instr_o is a 16-bit instruction.

Behaviour:
- Reset (reset=0, asynchronous):
  - queue empty; fetch_pc = RESET_PC word-aligned; pc_o = RESET_PC.
  - drop_first = RESET_PC[1]; outstanding = 0; drop_resp = 0.
  - All outputs 0 except pc_o and fetch_addr_o.
- Queue:
  - circular buffer of DEPTH_HW parcels with head/tail pointers and a count of 0..DEPTH_HW.
  - Count and pointers wrap modulo DEPTH_HW; no overflow is possible, by the request rule.
- Request rule:
  - at most one outstanding request.
  - fetch_req_o = !outstanding && !flush_i && (DEPTH_HW - count) >= 2.
  - A request is accepted the cycle it is asserted, which sets outstanding. fetch_addr_o = fetch_pc.
- Response (fetch_valid_i while outstanding):
  - If drop_resp: discard the word; clear drop_resp and outstanding.
  - Else if drop_first: push fetch_data_i[31:16] only, then clear drop_first.
  - Else: push [15:0] then [31:16].
  - In all non-dropped cases: fetch_pc += 4, outstanding clears.
  - fetch_valid_i without an outstanding request is ignored.
- Output:
  - head parcel H0, next parcel H1.
  - If H0[1:0] != 2'b11: compressed. instr_valid_o = count>=1, instr_o = {16'h0,H0}, is_comp_o = 1.
  - Else: instr_valid_o = count>=2, instr_o = {H1,H0}, is_comp_o = 0.
  - Outputs are combinational from registered queue state. A parcel pushed in cycle N is visible in cycle N+1.
- Pop on instr_valid_o && instr_ready_i: pop 1 or 2 parcels; pc_o += 2 or 4.
  - Push and pop in the same cycle are both applied; count updates by push minus pop.
- Flush (highest priority, overrides push/pop that cycle):
  - queue empty; pc_o = {redirect_pc_i[31:1],1'b0}; fetch_pc = {redirect_pc_i[31:2],2'b00}.
  - drop_first = redirect_pc_i[1].
  - If a request is outstanding and its response does not arrive that same cycle: fetch_kill_o = 1 for that cycle and drop_resp = 1.
  - A response arriving in the flush cycle is discarded and clears outstanding.
  - instr_valid_o is 0 the cycle after a flush.
- Back-to-back flushes: each one re-targets; drop_resp remains set until the stale response returns.
- Stall: with instr_ready_i=0, instr_o/pc_o/is_comp_o hold stable while instr_valid_o=1.

Test Plan:
1. Reset with RESET_PC=0; I-cache returns 32'h0001_4501 to the request at 0x0 → instr_o=0x4501, pc_o=0x0, is_comp_o=1. Next: instr_o=0x0001, pc_o=0x2, is_comp_o=1.
2. Words 32'h1234_0093 then 32'h0000_5678 at 0x0/0x4, ready held 1 → instr_o=0x1234_0093 at pc 0x0, then 0x5678 (comp) at 0x4.
3. Straddle case: words 32'h0513_4505 then 32'h0000_0000 → 0x4505 at pc 0x0 (comp); then 0x0000_0513 at pc 0x2, is_comp_o=0, valid only after the second word arrives.
4. flush_i with redirect_pc_i=0x0000_0106 while a request is outstanding → fetch_kill_o pulses 1 cycle; stale response discarded. Next fetch_addr_o=0x104; only the upper parcel is pushed; first instruction has pc_o=0x106.
5. instr_ready_i=0 for 20 cycles with continuous responses → count saturates at DEPTH_HW or DEPTH_HW-1; fetch_req_o=0 when fewer than 2 free parcels; no parcel lost; outputs stable.
6. Assert reset mid-response with a half-filled queue → all outputs clear asynchronously; after release, first request is to RESET_PC.

Source files
------------

// File: rtl/fetch_align_queue.sv
// Halfword prefetch queue: fetches aligned 32-bit words from the I-cache and hands
// out whole 16/32-bit instructions with their PC, re-aligning straddling 32-bit ones.
module fetch_align_queue #(
    parameter int unsigned DEPTH_HW = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush_i,
    input  logic [31:0] redirect_pc_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    output logic        fetch_kill_o,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_data_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        is_comp_o
);
    localparam int unsigned PW = $clog2(DEPTH_HW);
    localparam logic [PW:0] DEPTH_CNT = (PW+1)'(DEPTH_HW);
    localparam logic [PW:0] CNT_ONE   = (PW+1)'(1);
    localparam logic [PW:0] CNT_TWO   = (PW+1)'(2);

    logic [15:0]   mem [DEPTH_HW];
    logic [PW-1:0] head_q, tail_q;
    logic [PW-1:0] head_nx1, tail_nx1;
    logic [PW:0]   count_q;
    logic [31:0]   fetch_pc_q, pc_q;
    logic          drop_first_q, outstanding_q, drop_resp_q;

    logic [15:0]   h0, h1;
    logic          h0_comp;
    logic          resp_fire, push_fire, pop_fire;
    logic [1:0]    push_n, pop_n;
    logic [PW:0]   free_cnt;

    assign head_nx1 = head_q + PW'(1);
    assign tail_nx1 = tail_q + PW'(1);
    assign h0       = mem[head_q];
    assign h1       = mem[head_nx1];
    assign h0_comp  = (h0[1:0] != 2'b11);
    assign free_cnt = DEPTH_CNT - count_q;

    // Instruction handshake: a transfer happens on instr_valid_o && instr_ready_i;
    // instr_o/pc_o/is_comp_o stay stable while valid is held without ready, and
    // valid never depends on ready. Fetch requests need no ready: accepted when raised.
    always_comb begin
        fetch_req_o   = 1'b0;
        fetch_kill_o  = 1'b0;
        instr_valid_o = 1'b0;
        instr_o       = 32'h0;
        is_comp_o     = 1'b0;
        resp_fire     = fetch_valid_i && outstanding_q;
        push_fire     = resp_fire && !drop_resp_q && !flush_i;
        push_n        = 2'd0;
        pop_n         = 2'd0;

        // Gated by reset so that every control output reads 0 while reset is held.
        fetch_req_o  = reset && !outstanding_q && !flush_i && (free_cnt >= CNT_TWO);
        fetch_kill_o = flush_i && outstanding_q && !fetch_valid_i;

        instr_valid_o = h0_comp ? (count_q >= CNT_ONE) : (count_q >= CNT_TWO);
        if (instr_valid_o) begin
            instr_o   = h0_comp ? {16'h0, h0} : {h1, h0};
            is_comp_o = h0_comp;
        end
        pop_fire = instr_valid_o && instr_ready_i && !flush_i;

        if (push_fire) push_n = drop_first_q ? 2'd1 : 2'd2;
        if (pop_fire)  pop_n  = h0_comp ? 2'd1 : 2'd2;
    end

    assign fetch_addr_o = fetch_pc_q;
    assign pc_o         = pc_q;

    // Parcel storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            if (drop_first_q) begin
                mem[tail_q] <= fetch_data_i[31:16];
            end else begin
                mem[tail_q]   <= fetch_data_i[15:0];
                mem[tail_nx1] <= fetch_data_i[31:16];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
            pc_q          <= RESET_PC;
            drop_first_q  <= RESET_PC[1];
            outstanding_q <= 1'b0;
            drop_resp_q   <= 1'b0;
        end else if (flush_i) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            pc_q         <= {redirect_pc_i[31:1], 1'b0};
            fetch_pc_q   <= {redirect_pc_i[31:2], 2'b00};
            drop_first_q <= redirect_pc_i[1];
            // A response landing now is the one being cancelled; otherwise wait for it.
            if (outstanding_q) begin
                outstanding_q <= !fetch_valid_i;
                drop_resp_q   <= !fetch_valid_i;
            end
        end else begin
            head_q  <= head_q + PW'(pop_n);
            tail_q  <= tail_q + PW'(push_n);
            count_q <= count_q + (PW+1)'(push_n) - (PW+1)'(pop_n);
            if (pop_fire) pc_q <= pc_q + (h0_comp ? 32'd2 : 32'd4);
            if (resp_fire) begin
                outstanding_q <= 1'b0;
                if (drop_resp_q) begin
                    drop_resp_q <= 1'b0;
                end else begin
                    fetch_pc_q   <= fetch_pc_q + 32'd4;
                    drop_first_q <= 1'b0;
                end
            end else if (fetch_req_o) begin
                outstanding_q <= 1'b1;
            end
        end
    end

endmodule
